// File: rtl/light_lamp_driver.sv
// Lamp driver for the three-direction traffic-light controller: decodes the one-hot
// pass signals into R/Y/G lamps and a countdown, with all-red flashing on malformed input.
module light_lamp_driver #(
  parameter int L           = 10,
  parameter int S           = 3,
  parameter int RW          = 8,
  parameter int FAULT_CYC   = 2,
  parameter int RECOVER_CYC = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          J,
  input  logic          P,
  input  logic          C,
  output logic [2:0]    J_lamp,
  output logic [2:0]    P_lamp,
  output logic [2:0]    C_lamp,
  output logic [RW-1:0] remain,
  output logic          fault,
  output logic          seq_err
);

  if (L <= S) begin : g_bad_len
    $error("light_lamp_driver: L must be greater than S");
  end
  if (L + 2 * S >= 2 ** RW) begin : g_bad_rw
    $error("light_lamp_driver: RW too narrow for L+2*S");
  end
  if (FAULT_CYC < 1 || RECOVER_CYC < 1 || FAULT_CYC > 255 || RECOVER_CYC > 255) begin : g_bad_cyc
    $error("light_lamp_driver: FAULT_CYC/RECOVER_CYC out of range");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FAULT} state_t;
  typedef enum logic [1:0] {PH_NONE, PH_J, PH_P, PH_C} phase_t;

  localparam logic [RW-1:0] DUR_J = RW'(L + S);
  localparam logic [RW-1:0] DUR_P = RW'(L - S);
  localparam logic [RW-1:0] DUR_C = RW'(L + 2 * S);
  localparam logic [RW-1:0] S_W   = RW'(S);
  localparam logic [RW-1:0] ONE_W = RW'(1);
  localparam logic [7:0]    FC    = 8'(FAULT_CYC);
  localparam logic [7:0]    RC    = 8'(RECOVER_CYC);

  function automatic logic [RW-1:0] dur(input phase_t ph);
    case (ph)
      PH_J:    dur = DUR_J;
      PH_P:    dur = DUR_P;
      PH_C:    dur = DUR_C;
      default: dur = '0;
    endcase
  endfunction

  function automatic phase_t succ(input phase_t ph);
    case (ph)
      PH_J:    succ = PH_P;
      PH_P:    succ = PH_C;
      PH_C:    succ = PH_J;
      default: succ = PH_NONE;
    endcase
  endfunction

  state_t        state_reg, state_next;
  phase_t        phase_reg, phase_next;
  logic [RW-1:0] remain_reg, remain_next;
  logic [7:0]    bad_reg, bad_next;
  logic [7:0]    rec_reg, rec_next;
  logic          flash_reg, flash_next;
  logic          seq_err_reg, seq_err_next;
  logic          fault_reg;
  logic [8:0]    lamps_reg, lamps_next;

  logic   sample_valid;
  phase_t sample_ph;

  always_comb begin
    sample_valid = 1'b1;
    sample_ph    = PH_NONE;
    case ({J, P, C})
      3'b100:  sample_ph = PH_J;
      3'b010:  sample_ph = PH_P;
      3'b001:  sample_ph = PH_C;
      default: sample_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      phase_reg   <= PH_NONE;
      remain_reg  <= '0;
      bad_reg     <= '0;
      rec_reg     <= '0;
      flash_reg   <= 1'b0;
      seq_err_reg <= 1'b0;
      fault_reg   <= 1'b0;
      lamps_reg   <= {3{3'b100}};
    end else begin
      state_reg   <= state_next;
      phase_reg   <= phase_next;
      remain_reg  <= remain_next;
      bad_reg     <= bad_next;
      rec_reg     <= rec_next;
      flash_reg   <= flash_next;
      seq_err_reg <= seq_err_next;
      fault_reg   <= (state_next == ST_FAULT);
      lamps_reg   <= lamps_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    phase_next   = phase_reg;
    remain_next  = remain_reg;
    bad_next     = bad_reg;
    rec_next     = rec_reg;
    flash_next   = flash_reg;
    seq_err_next = seq_err_reg;
    case (state_reg)
      ST_FAULT: begin
        flash_next = ~flash_reg;
        bad_next   = '0;
        if (sample_valid) begin
          // phase_reg holds the last valid sample, which is what recovery compares against
          rec_next   = (sample_ph == phase_reg) ? rec_reg + 8'd1 : 8'd1;
          phase_next = sample_ph;
          if (rec_next >= RC) begin
            state_next  = ST_RUN;
            remain_next = dur(sample_ph);
            rec_next    = '0;
          end
        end else begin
          rec_next = '0;
        end
      end
      default: begin
        if (sample_valid) begin
          bad_next   = '0;
          state_next = ST_RUN;
          phase_next = sample_ph;
          if (state_reg == ST_RUN && sample_ph == phase_reg) begin
            remain_next = (remain_reg > ONE_W) ? remain_reg - ONE_W : ONE_W;
          end else begin
            remain_next = dur(sample_ph);
            if (state_reg == ST_RUN && sample_ph != succ(phase_reg)) begin
              seq_err_next = 1'b1;
            end
          end
        end else if (bad_reg + 8'd1 >= FC) begin
          state_next  = ST_FAULT;
          bad_next    = '0;
          rec_next    = '0;
          remain_next = '0;
          flash_next  = 1'b1;
        end else begin
          bad_next = bad_reg + 8'd1;
        end
      end
    endcase
  end

  // Lamp slice gi: 0 = J, 1 = P, 2 = C
  for (genvar gi = 0; gi < 3; gi++) begin : g_lamp
    localparam phase_t DIR = phase_t'(2'(gi + 1));
    assign lamps_next[3*gi +: 3] =
      (state_next == ST_FAULT) ? {flash_next, 2'b00} :
      (state_next == ST_RUN && phase_next == DIR) ?
        ((remain_next > S_W) ? 3'b001 : 3'b010) : 3'b100;
  end

  assign J_lamp  = lamps_reg[2:0];
  assign P_lamp  = lamps_reg[5:3];
  assign C_lamp  = lamps_reg[8:6];
  assign remain  = remain_reg;
  assign fault   = fault_reg;
  assign seq_err = seq_err_reg;

endmodule

// File: tb/tb_light_lamp_driver.sv
// Scoreboard bench for light_lamp_driver: directed scenarios followed by random
// samples, checked against a phase-table reference model.
module tb_light_lamp_driver;

  localparam int L = 10, S = 3, RW = 8, FCYC = 2, RCYC = 3;
  localparam int M_IDLE = 0, M_RUN = 1, M_FLT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          J = 1'b0, P = 1'b0, C = 1'b0;
  logic [2:0]    J_lamp, P_lamp, C_lamp;
  logic [RW-1:0] remain;
  logic          fault, seq_err;

  light_lamp_driver #(.L(L), .S(S), .RW(RW), .FAULT_CYC(FCYC), .RECOVER_CYC(RCYC)) dut (
    .clk(clk), .rst(rst), .J(J), .P(P), .C(C),
    .J_lamp(J_lamp), .P_lamp(P_lamp), .C_lamp(C_lamp),
    .remain(remain), .fault(fault), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] in;
    logic [2:0] jl, pl, cl;
    int         rem;
    logic       flt, se;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   txn   = 0;

  // Reference model: mode, active phase index (0=J,1=P,2=C), seconds left.
  int m_mode = M_IDLE, m_ph = -1, m_rem = 0, m_bad = 0, m_rec = 0;
  bit m_flash = 1'b0, m_seq = 1'b0;
  int dur_tab[3] = '{L + S, L - S, L + 2 * S};

  task automatic model_step(input bit rn, input bit j, input bit p, input bit c, output exp_t e);
    int n, idx;
    logic [2:0] lm[3];
    n   = int'(j) + int'(p) + int'(c);
    idx = j ? 0 : (p ? 1 : 2);
    if (!rn) begin
      m_mode = M_IDLE; m_ph = -1; m_rem = 0; m_bad = 0; m_rec = 0; m_flash = 0; m_seq = 0;
    end else if (m_mode == M_FLT) begin
      if (n == 1) begin
        m_rec = (idx == m_ph) ? m_rec + 1 : 1;
        m_ph  = idx;
        if (m_rec >= RCYC) begin
          m_mode = M_RUN; m_rem = dur_tab[idx]; m_rec = 0;
        end else m_flash = !m_flash;
      end else begin
        m_rec = 0; m_flash = !m_flash;
      end
    end else if (n == 1) begin
      if (m_mode == M_RUN && idx == m_ph) m_rem = (m_rem > 1) ? m_rem - 1 : 1;
      else begin
        if (m_mode == M_RUN && idx != (m_ph + 1) % 3) m_seq = 1;
        m_rem = dur_tab[idx];
      end
      m_ph = idx; m_bad = 0; m_mode = M_RUN;
    end else begin
      m_bad++;
      if (m_bad >= FCYC) begin
        m_mode = M_FLT; m_flash = 1; m_rec = 0; m_bad = 0; m_rem = 0;
      end
    end
    for (int d = 0; d < 3; d++) begin
      if (m_mode == M_FLT)                    lm[d] = {m_flash, 2'b00};
      else if (m_mode == M_RUN && d == m_ph)  lm[d] = (m_rem > S) ? 3'b001 : 3'b010;
      else                                    lm[d] = 3'b100;
    end
    e.in  = {rn, j, p, c};
    e.jl  = lm[0]; e.pl = lm[1]; e.cl = lm[2];
    e.rem = (m_mode == M_RUN) ? m_rem : 0;
    e.flt = (m_mode == M_FLT);
    e.se  = m_seq;
  endtask

  task automatic drive(input bit rn, input bit j, input bit p, input bit c, input int n);
    exp_t e;
    repeat (n) begin
      @(negedge clk);
      rst = rn; J = j; P = p; C = c;
      model_step(rn, j, p, c, e);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: outputs are valid every cycle, one posedge after the sample.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        txn++;
        if ({J_lamp, P_lamp, C_lamp, remain, fault, seq_err} !==
            {e.jl, e.pl, e.cl, RW'(e.rem), e.flt, e.se}) begin
          bad++;
          $display("FAIL txn%0d in(rst,J,P,C)=%b: got J=%b P=%b C=%b rem=%0d fault=%b seq_err=%b, expected J=%b P=%b C=%b rem=%0d fault=%b seq_err=%b",
                   txn, e.in, J_lamp, P_lamp, C_lamp, remain, fault, seq_err,
                   e.jl, e.pl, e.cl, e.rem, e.flt, e.se);
        end else begin
          $display("txn %0d in(rst,J,P,C)=%b J=%b P=%b C=%b rem=%0d fault=%b seq_err=%b",
                   txn, e.in, J_lamp, P_lamp, C_lamp, remain, fault, seq_err);
        end
      end
    end
  end

  initial begin
    int cur, r, k;
    drive(0, 0, 0, 0, 2);
    // full legal cycle, then J held past its duration
    drive(1, 1, 0, 0, 13); drive(1, 0, 1, 0, 7); drive(1, 0, 0, 1, 16);
    drive(1, 1, 0, 0, 20);
    // glitch at remain=8, then two-cycle dropout into FAULT
    drive(0, 0, 0, 0, 1);
    drive(1, 1, 0, 0, 6); drive(1, 0, 0, 0, 1); drive(1, 1, 0, 0, 1);
    drive(1, 0, 0, 0, 2); drive(1, 1, 1, 1, 3);
    drive(1, 0, 1, 0, 3);
    // recovery interrupted by a different phase
    drive(1, 0, 0, 0, 2); drive(1, 0, 1, 0, 1); drive(1, 1, 0, 0, 3);
    // illegal J->C, then legal phases keep the sticky flag
    drive(1, 1, 0, 0, 2); drive(1, 0, 0, 1, 4);
    drive(1, 1, 0, 0, 3); drive(1, 0, 1, 0, 3); drive(1, 0, 0, 1, 5);
    // reset mid-C, IDLE dropout into FAULT, reset mid-FAULT
    drive(0, 0, 0, 1, 1);
    drive(1, 0, 0, 0, 2); drive(1, 0, 0, 1, 2);
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 0, 1, 2); drive(1, 1, 1, 0, 2); drive(1, 0, 0, 0, 2);
    drive(0, 0, 0, 0, 1);
    drive(1, 0, 1, 0, 3);
    // random traffic
    cur = 1;
    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70) drive(1, cur == 0, cur == 1, cur == 2, 1);
      else if (r < 82) begin
        cur = (cur + 1) % 3;
        drive(1, cur == 0, cur == 1, cur == 2, 1);
      end else if (r < 86) begin
        cur = $urandom_range(0, 2);
        drive(1, cur == 0, cur == 1, cur == 2, 1);
      end else if (r < 98) begin
        k = $urandom_range(0, 4);
        case (k)
          0: drive(1, 0, 0, 0, 1);
          1: drive(1, 0, 1, 1, 1);
          2: drive(1, 1, 0, 1, 1);
          3: drive(1, 1, 1, 0, 1);
          default: drive(1, 1, 1, 1, 1);
        endcase
      end else drive(0, 0, 0, 0, 1);
    end
    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
